// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives InstructionMem and loads IF/ID.
// Handles stall, flush, redirect and HALT, and counts valid fetches.
module fetch_stage #(
    parameter logic [15:0] ResetPc    = 16'h0000,
    parameter logic [3:0]  HaltOpcode = 4'hF,
    parameter logic [15:0] NopInstr   = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [15:0] Address,
    input  logic [15:0] Content,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [15:0] RedirectPc,
    output logic [15:0] IfIdInstr,
    output logic [15:0] IfIdPcPlus1,
    output logic        IfIdValid,
    output logic        Halted,
    output logic [15:0] FetchCount
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp1_q, pcp1_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [15:0] count_q, count_d;
    logic [15:0] pc_plus1;

    // 16-bit add wraps FFFF -> 0000 naturally
    assign pc_plus1 = pc_q + 16'd1;

    // Next-state: redirect beats stall, stall beats flush, flush beats a normal fetch
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcp1_d   = pcp1_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        case (state_q)
            S_BOOT: begin
                // One idle cycle after reset; all control inputs ignored
                state_d = S_RUN;
            end
            S_RUN: begin
                if (Redirect) begin
                    pc_d    = RedirectPc;
                    instr_d = NopInstr;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    // hold everything
                end else if (Flush) begin
                    pc_d    = pc_plus1;
                    instr_d = NopInstr;
                    valid_d = 1'b0;
                end else begin
                    instr_d = Content;
                    pcp1_d  = pc_plus1;
                    valid_d = 1'b1;
                    count_d = count_q + 16'd1;
                    if (Content[15:12] == HaltOpcode) begin
                        // PC parks on the HALT word; it still drains through IF/ID once
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end
            end
            S_HALT: begin
                instr_d = NopInstr;
                valid_d = 1'b0;
                if (Redirect) begin
                    pc_d     = RedirectPc;
                    state_d  = S_RUN;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_BOOT;
            pc_q     <= ResetPc;
            instr_q  <= NopInstr;
            pcp1_q   <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp1_q   <= pcp1_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign Address     = pc_q;
    assign IfIdInstr   = instr_q;
    assign IfIdPcPlus1 = pcp1_q;
    assign IfIdValid   = valid_q;
    assign Halted      = halted_q;
    assign FetchCount  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-edge vectors plus hand-written
// async-reset sequences. Memory model: Mem[a] = {4'h1, a[11:0]}, and when
// halt_en is set, Mem[4] = F123 (a HALT).
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Address;
    logic [15:0] Content;
    logic        Stall, Flush, Redirect;
    logic [15:0] RedirectPc;
    logic [15:0] IfIdInstr, IfIdPcPlus1, FetchCount;
    logic        IfIdValid, Halted;
    logic        halt_en;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .Clk(Clk), .Reset_n(Reset_n), .Address(Address), .Content(Content),
        .Stall(Stall), .Flush(Flush), .Redirect(Redirect), .RedirectPc(RedirectPc),
        .IfIdInstr(IfIdInstr), .IfIdPcPlus1(IfIdPcPlus1), .IfIdValid(IfIdValid),
        .Halted(Halted), .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    assign Content = (halt_en && Address == 16'h0004) ? 16'hF123 : {4'h1, Address[11:0]};

    typedef struct {
        logic        he, st, fl, rd;
        logic [15:0] rpc;
        logic [15:0] addr, instr, pcp1;
        logic        v, h;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic he, st, fl, rd, input logic [15:0] rpc,
                       input logic [15:0] addr, instr, pcp1,
                       input logic v, h, input logic [15:0] cnt);
        vec_t x;
        x.he = he; x.st = st; x.fl = fl; x.rd = rd; x.rpc = rpc;
        x.addr = addr; x.instr = instr; x.pcp1 = pcp1; x.v = v; x.h = h; x.cnt = cnt;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] addr, instr, pcp1,
                           input logic v, h, input logic [15:0] cnt);
        chk({tag, " Address"},     Address,     addr);
        chk({tag, " IfIdInstr"},   IfIdInstr,   instr);
        chk({tag, " IfIdPcPlus1"}, IfIdPcPlus1, pcp1);
        chk({tag, " IfIdValid"},   {15'd0, IfIdValid}, {15'd0, v});
        chk({tag, " Halted"},      {15'd0, Halted},    {15'd0, h});
        chk({tag, " FetchCount"},  FetchCount,  cnt);
    endtask

    task automatic drive(input logic he, st, fl, rd, input logic [15:0] rpc);
        halt_en = he; Stall = st; Flush = fl; Redirect = rd; RedirectPc = rpc;
    endtask

    initial begin
        //   he st fl rd rpc        addr      instr     pcp1      v  h  cnt
        add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000); // BOOT edge
        add(0, 0, 0, 0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1, 0, 16'h0001);
        add(0, 0, 0, 0, 16'h0000, 16'h0002, 16'h1001, 16'h0002, 1, 0, 16'h0002);
        add(0, 0, 0, 0, 16'h0000, 16'h0003, 16'h1002, 16'h0003, 1, 0, 16'h0003);
        add(0, 0, 0, 0, 16'h0000, 16'h0004, 16'h1003, 16'h0004, 1, 0, 16'h0004);
        add(0, 0, 0, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1, 0, 16'h0005);
        add(0, 1, 0, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1, 0, 16'h0005); // stall
        add(0, 1, 0, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1, 0, 16'h0005); // stall
        add(0, 0, 0, 0, 16'h0000, 16'h0006, 16'h1005, 16'h0006, 1, 0, 16'h0006);
        add(0, 0, 0, 0, 16'h0000, 16'h0007, 16'h1006, 16'h0007, 1, 0, 16'h0007);
        add(0, 0, 0, 0, 16'h0000, 16'h0008, 16'h1007, 16'h0008, 1, 0, 16'h0008);
        add(0, 0, 1, 0, 16'h0000, 16'h0009, 16'h0000, 16'h0008, 0, 0, 16'h0008); // flush
        add(0, 0, 0, 0, 16'h0000, 16'h000A, 16'h1009, 16'h000A, 1, 0, 16'h0009);
        add(0, 1, 1, 1, 16'h0013, 16'h0013, 16'h0000, 16'h000A, 0, 0, 16'h0009); // redirect wins
        add(0, 0, 0, 0, 16'h0000, 16'h0014, 16'h1013, 16'h0014, 1, 0, 16'h000A);
        add(0, 1, 1, 0, 16'h0000, 16'h0014, 16'h1013, 16'h0014, 1, 0, 16'h000A); // stall beats flush
        add(0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0014, 0, 0, 16'h000A);
        add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1FFF, 16'h0000, 1, 0, 16'h000B); // wrap
        add(0, 0, 0, 1, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 0, 0, 16'h000B);
        add(0, 0, 0, 0, 16'h0000, 16'h0003, 16'h1002, 16'h0003, 1, 0, 16'h000C);
        add(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h1003, 16'h0004, 1, 0, 16'h000D);
        add(1, 0, 0, 0, 16'h0000, 16'h0004, 16'hF123, 16'h0005, 1, 1, 16'h000E); // HALT fetched
        add(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0005, 0, 1, 16'h000E);
        add(1, 1, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0005, 0, 1, 16'h000E);
        add(1, 0, 1, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0005, 0, 1, 16'h000E);
        add(1, 1, 1, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0005, 0, 1, 16'h000E);
        add(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0005, 0, 1, 16'h000E);
        add(1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 0, 0, 16'h000E); // leave HALT
        add(0, 0, 0, 0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1, 0, 16'h000F);

        // Reset held for 3 cycles, with control inputs active to show they are ignored
        Reset_n = 1'b0;
        drive(0, 1, 1, 1, 16'h0033);
        repeat (3) begin
            @(posedge Clk); #1;
            chk_all("in_reset", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(0, 0, 0, 0, 16'h0000);

        foreach (vecs[i]) begin
            drive(vecs[i].he, vecs[i].st, vecs[i].fl, vecs[i].rd, vecs[i].rpc);
            @(posedge Clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].pcp1,
                    vecs[i].v, vecs[i].h, vecs[i].cnt);
        end

        // Go back into HALT, then pull reset between edges with a redirect in flight
        drive(1, 0, 0, 1, 16'h0004);
        @(posedge Clk); #1;
        chk_all("rehalt_redir", 16'h0004, 16'h0000, 16'h0001, 0, 0, 16'h000F);
        drive(1, 0, 0, 0, 16'h0000);
        @(posedge Clk); #1;
        chk_all("rehalt", 16'h0004, 16'hF123, 16'h0005, 1, 1, 16'h0010);
        drive(1, 1, 0, 1, 16'h0020);
        #3;
        Reset_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        @(posedge Clk); #1;
        chk_all("rst_hold", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        @(negedge Clk);
        drive(0, 0, 0, 0, 16'h0000);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk_all("reboot", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        @(posedge Clk); #1;
        chk_all("refetch0", 16'h0001, 16'h1000, 16'h0001, 1, 0, 16'h0001);

        // Async reset in the middle of a stall
        drive(0, 1, 0, 0, 16'h0000);
        @(posedge Clk); #1;
        chk_all("stall_pre", 16'h0001, 16'h1000, 16'h0001, 1, 0, 16'h0001);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all("async_rst_stall", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 16-bit pipelined MIPS core; sits directly upstream of InstructionMem and owns the program counter.
- Drives the word address into the combinational instruction memory and captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect and halt, and keeps a fetched-instruction counter.

Parameters:
- ResetPc, 16'h0000, PC value loaded on reset.
- HaltOpcode, 4'hF, value of Instr[15:12] that marks a HALT instruction.
- NopInstr, 16'h0000, instruction word inserted into IF/ID on flush/bubble.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Address  output  16  word address to InstructionMem; equals the PC register.
- Content  input  16  instruction word returned combinationally by InstructionMem for Address.
- Stall  input  1  hazard-unit stall; hold PC and IF/ID.
- Flush  input  1  squash the instruction entering IF/ID this cycle.
- Redirect  input  1  branch taken or jump from a later stage.
- RedirectPc  input  16  target PC for Redirect.
- IfIdInstr  output  16  IF/ID registered instruction.
- IfIdPcPlus1  output  16  IF/ID registered PC+1 of that instruction.
- IfIdValid  output  1  IF/ID holds a real (non-bubble) instruction.
- Halted  output  1  fetch has stopped on a HALT instruction.
- FetchCount  output  16  number of instructions written into IF/ID as valid.

Behaviour:
- Address is word addressed. Sequential PC advance is +1, with 16-bit wrap: 16'hFFFF -> 16'h0000.
- Address = PC register. There is no combinational path from Content to Address.
- State machine: BOOT, RUN, HALT.
- On Reset_n low, asynchronously and immediately:
  - PC = ResetPc; state = BOOT.
  - IfIdInstr = NopInstr; IfIdPcPlus1 = 0; IfIdValid = 0.
  - Halted = 0; FetchCount = 0.
- BOOT: lasts exactly one cycle after reset deasserts. PC and IF/ID are held. Next state is RUN. Stall, Flush and Redirect are ignored in BOOT.
- RUN, per rising edge, in priority order:
  1. Redirect=1:
     - PC <= RedirectPc.
     - IF/ID <= bubble (NopInstr, IfIdValid=0; IfIdPcPlus1 unchanged).
     - Redirect overrides Stall and Flush.
  2. Stall=1 (no Redirect): PC, IF/ID and FetchCount all hold.
     - With Stall and Flush both high, Stall wins and IF/ID holds.
  3. Flush=1 (no Redirect, no Stall): PC <= PC+1; IF/ID <= bubble.
  4. Otherwise:
     - IfIdInstr <= Content; IfIdPcPlus1 <= PC+1; IfIdValid <= 1.
     - FetchCount <= FetchCount+1, wrapping at 16'hFFFF -> 0.
     - If Content[15:12]==HaltOpcode: state <= HALT and PC holds. Otherwise PC <= PC+1.
- HALT:
  - Halted=1 (registered, asserted from the first cycle in HALT).
  - PC holds. IF/ID <= bubble each cycle after entry, so the HALT instruction itself drains once. FetchCount holds.
  - Redirect=1 leaves HALT: PC <= RedirectPc, state <= RUN, Halted <= 0.
  - Stall and Flush have no effect in HALT.
- Latency: the instruction at address A appears on IfIdInstr one edge after Address=A with no stall.
- IfIdPcPlus1 is only meaningful while IfIdValid=1.
- Reset asserted mid-operation: all state returns to reset values at once, including mid-stall and mid-HALT. An in-flight Redirect is lost.

Test Plan:
- Reset/boot: hold Reset_n=0 for 3 cycles, then release.
  -> While in reset: Address=0000, IfIdValid=0, FetchCount=0.
  -> Address stays 0000 for the BOOT cycle, then reads 0000, 0001, 0002 on successive edges.
  -> IfIdInstr = Mem[0], then Mem[1]; IfIdPcPlus1 = 0001, then 0002.
- Stall: Stall=1 for 2 cycles while Address=0005.
  -> Address stays 0005; IfIdInstr/IfIdValid/FetchCount are unchanged.
  -> After release, IfIdInstr=Mem[5] and IfIdPcPlus1=0006.
- Redirect vs Stall: Redirect=1, RedirectPc=0013, Stall=1, Flush=1 in the same cycle.
  -> Next Address=0013; IfIdValid=0; IfIdInstr=NopInstr; FetchCount unchanged.
  -> The following edge gives IfIdInstr=Mem[19].
- Flush: Flush=1 alone at Address=0008.
  -> Next Address=0009; IfIdValid=0 for one cycle; FetchCount not incremented.
- Halt: place F123 at address 0004 and run.
  -> IfIdInstr=F123 with IfIdValid=1; Halted=1; Address stays 0004 for 5 cycles with IfIdValid=0.
  -> Then Redirect to 0000: Halted=0 and fetch resumes from 0000.
- Wrap and async reset: Redirect to FFFF.
  -> Next Address=0000 and IfIdPcPlus1=0000.
  -> Pull Reset_n low between clock edges: outputs return to reset values without waiting for an edge.
